// File: rtl/cla_seq_ctrl_if.sv
// cla_seq_ctrl_if: operation request / result handshake bundle
interface cla_seq_ctrl_if #(parameter int NIBBLES = 4);
  localparam int W = 4 * NIBBLES;
  logic in_valid, in_ready, in_sub, in_cin;
  logic [W-1:0] in_a, in_b;
  logic out_valid, out_ready, out_cout, out_ovf, out_zero;
  logic [W-1:0] out_sum;
  modport master (output in_valid, in_a, in_b, in_sub, in_cin, out_ready,
                  input in_ready, out_valid, out_sum, out_cout, out_ovf, out_zero);
  modport slave (input in_valid, in_a, in_b, in_sub, in_cin, out_ready,
                 output in_ready, out_valid, out_sum, out_cout, out_ovf, out_zero);
endinterface

// File: rtl/cla_seq_ctrl.sv
// cla_seq_ctrl: nibble-serial adder/subtractor built around a single 4-bit CLA
module cla_4bit (
  input  logic [3:0] A,
  input  logic [3:0] B,
  input  logic       Cin,
  output logic [3:0] S,
  output logic       Cout
);
  logic [3:0] g, p;
  logic [4:0] c;
  assign g = A & B;
  assign p = A ^ B;
  assign c[0] = Cin;
  assign c[1] = g[0] | (p[0] & c[0]);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c[0]);
  assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
              | (p[3] & p[2] & p[1] & p[0] & c[0]);
  assign S = p ^ c[3:0];
  assign Cout = c[4];
endmodule

module cla_seq_ctrl #(parameter int NIBBLES = 4) (
  input logic clk,
  input logic rst,
  cla_seq_ctrl_if.slave bus
);
  localparam int W = 4 * NIBBLES;
  localparam int IW = $clog2(NIBBLES);
  typedef enum logic [1:0] {IDLE, ADD, HOLD} state_t;
  state_t state_q, state_d;
  logic [W-1:0] a_q, a_d, b_q, b_d, res_q, res_d, sum_q, sum_d;
  logic [IW-1:0] idx_q, idx_d;
  logic carry_q, carry_d, cout_q, cout_d, ovf_q, ovf_d, zero_q, zero_d;
  logic [3:0] s;
  logic co, last;
  cla_4bit u_cla (.A(a_q[idx_q*4 +: 4]), .B(b_q[idx_q*4 +: 4]), .Cin(carry_q), .S(s), .Cout(co));
  assign last = idx_q == IW'(NIBBLES - 1);
  assign bus.in_ready = (state_q == IDLE) | ((state_q == HOLD) & bus.out_ready);
  assign bus.out_valid = state_q == HOLD;
  assign bus.out_sum = sum_q;
  assign bus.out_cout = cout_q;
  assign bus.out_ovf = ovf_q;
  assign bus.out_zero = zero_q;
  always_comb begin
    state_d = state_q;
    a_d = a_q;
    b_d = b_q;
    res_d = res_q;
    idx_d = idx_q;
    carry_d = carry_q;
    sum_d = sum_q;
    cout_d = cout_q;
    ovf_d = ovf_q;
    zero_d = zero_q;
    if (state_q == ADD) begin
      res_d[idx_q*4 +: 4] = s;
      carry_d = co;
      idx_d = idx_q + 1'b1;
      if (last) begin
        // publish the whole result at once so partial sums never reach the outputs
        state_d = HOLD;
        sum_d = res_d;
        cout_d = co;
        ovf_d = (a_q[W-1] == b_q[W-1]) & (res_d[W-1] != a_q[W-1]);
        zero_d = res_d == '0;
      end
    end else if (bus.in_valid & bus.in_ready) begin
      state_d = ADD;
      a_d = bus.in_a;
      b_d = bus.in_sub ? ~bus.in_b : bus.in_b;
      carry_d = bus.in_sub | bus.in_cin;
      idx_d = '0;
    end else if ((state_q == HOLD) & bus.out_ready) begin
      state_d = IDLE;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q <= '0;
      b_q <= '0;
      res_q <= '0;
      idx_q <= '0;
      carry_q <= 1'b0;
      sum_q <= '0;
      cout_q <= 1'b0;
      ovf_q <= 1'b0;
      zero_q <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q <= a_d;
      b_q <= b_d;
      res_q <= res_d;
      idx_q <= idx_d;
      carry_q <= carry_d;
      sum_q <= sum_d;
      cout_q <= cout_d;
      ovf_q <= ovf_d;
      zero_q <= zero_d;
    end
  end
endmodule

// File: doc/cla_seq_ctrl.md
CLA_SEQ_CTRL -- requirements
Module: cla_seq_ctrl

Interface
REQ-001 The block SHALL have parameter NIBBLES, default 4, giving the operand width in 4-bit nibbles; legal range 2..8; W = 4*NIBBLES.
REQ-002 The block SHALL have port clk  input  1  single clock, all state updates on rising edge.
REQ-003 The block SHALL have port rst  input  1  synchronous, active-high reset.
REQ-004 The block SHALL have port in_valid  input  1  requester presents an operation.
REQ-005 The block SHALL have port in_ready  output  1  block accepts the operation this cycle.
REQ-006 The block SHALL have port in_a  input  W  operand A.
REQ-007 The block SHALL have port in_b  input  W  operand B.
REQ-008 The block SHALL have port in_sub  input  1  1 = A - B, 0 = A + B + in_cin.
REQ-009 The block SHALL have port in_cin  input  1  carry-in for add; ignored when in_sub = 1.
REQ-010 The block SHALL have port out_valid  output  1  result is available.
REQ-011 The block SHALL have port out_ready  input  1  consumer takes the result this cycle.
REQ-012 The block SHALL have port out_sum  output  W  result.
REQ-013 The block SHALL have port out_cout  output  1  carry out of the MSB; for subtract, 1 = no borrow.
REQ-014 The block SHALL have port out_ovf  output  1  two's-complement signed overflow.
REQ-015 The block SHALL have port out_zero  output  1  out_sum == 0.

Function
REQ-016 The block SHALL compute with exactly one instance of cla_4bit (ports A, B, Cin, S, Cout), processing one nibble per cycle, LSB nibble first.
REQ-017 The FSM SHALL have states IDLE, ADD, and HOLD.
REQ-018 in_ready SHALL be 1 in IDLE, equal to out_ready in HOLD, and 0 in ADD.
REQ-019 Accept (in_valid & in_ready) SHALL latch in_a, latch B_eff = in_sub ? ~in_b : in_b, set carry = in_sub ? 1 : in_cin, clear the nibble index to 0, and enter ADD.
REQ-020 Each ADD cycle SHALL feed nibble[idx] of A and B_eff plus the carry register to cla_4bit, write S into result nibble[idx], load Cout into the carry register, and increment idx.
REQ-021 After the ADD cycle with idx = NIBBLES-1, the FSM SHALL enter HOLD with out_valid = 1; out_valid SHALL therefore first be high NIBBLES cycles after the accepting edge.
REQ-022 Outputs SHALL be registered; out_sum, out_cout, out_ovf, and out_zero SHALL be stable while out_valid = 1 and out_ready = 0.
REQ-023 out_cout SHALL be the final carry register.
REQ-024 out_ovf SHALL be (A[W-1] == B_eff[W-1]) & (out_sum[W-1] != A[W-1]).
REQ-025 Partial results SHALL NOT be visible: out_valid SHALL be 0 throughout ADD.
REQ-026 In HOLD with out_ready = 1 and in_valid = 0, the FSM SHALL go to IDLE and out_valid SHALL fall on the next edge.
REQ-027 In HOLD with out_ready = 1 and in_valid = 1, the result SHALL be consumed and the new operation accepted on the same edge (state goes to ADD); no bubble SHALL be inserted into IDLE.
REQ-028 Sustained throughput SHALL be one operation per NIBBLES+1 cycles.
REQ-029 in_valid asserted during ADD SHALL be ignored; the requester SHALL hold it until in_ready is seen.
REQ-030 out_ready asserted while out_valid = 0 SHALL have no effect.

Reset
REQ-031 When rst = 1 at a clock edge, the block SHALL enter IDLE and force out_valid = 0, out_sum = 0, out_cout = 0, out_ovf = 0, out_zero = 0, idx = 0, and carry = 0.
REQ-032 rst SHALL take priority over every other event.
REQ-033 Reset during ADD or HOLD SHALL abort the operation and discard the result, and in_ready SHALL be 1 on the first cycle after reset.

Verification (NIBBLES = 4)
REQ-034 The bench SHALL cover: add 0x9ABC + 0x5544 with cin = 0 -> sum 0xF000, cout 0, ovf 0, zero 0, with out_valid exactly 4 cycles after accept.
REQ-035 The bench SHALL cover: add 0xFFFF + 0x0001 with cin = 0 -> sum 0x0000, cout 1, ovf 0, zero 1 (full ripple across all nibbles).
REQ-036 The bench SHALL cover: add 0x7FFF + 0x0000 with cin = 1 -> sum 0x8000, cout 0, ovf 1.
REQ-037 The bench SHALL cover subtract cases: 0x8000 - 0x0001 -> 0x7FFF, cout 1, ovf 1; and 0x0003 - 0x0005 with cin = 1 (ignored) -> 0xFFFE, cout 0, ovf 0.
REQ-038 The bench SHALL cover back-to-back operation: hold out_ready = 0 for 3 cycles, with outputs stable and in_ready = 0, then assert out_ready with in_valid = 1 -> the second op is accepted on the same edge and its result is valid 4 cycles later.
REQ-039 The bench SHALL cover reset in ADD: rst = 1 for one edge at idx = 2 -> out_valid is never raised for that op, all outputs are 0, and the next op completes correctly.
